// File: rtl/soc_timer_irq_unit.sv
// Memory-mapped compare timer: prescaled up-counter, compare register, match flag and
// level interrupt, attached to the core data bus through a req/gnt/rvalid slave port.
module soc_timer_irq_unit #(
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned PRESC_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic        gnt,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        irq
);

  localparam logic [2:0] RegCr    = 3'd0;
  localparam logic [2:0] RegSr    = 3'd1;
  localparam logic [2:0] RegCnt   = 3'd2;
  localparam logic [2:0] RegCmp   = 3'd3;
  localparam logic [2:0] RegPresc = 3'd4;

  logic                   r_en;
  logic                   r_ie;
  logic                   r_oneshot;
  logic                   r_match;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [CNT_WIDTH-1:0]   r_cmp;
  logic [PRESC_WIDTH-1:0] r_presc;
  logic [PRESC_WIDTH-1:0] r_psc;
  logic                   r_rvalid;
  logic [31:0]            r_rdata;
  logic                   r_err;
  logic                   r_irq;

  logic [2:0]             w_idx;
  logic                   w_mapped;
  logic                   w_wr;
  logic                   w_wr_cr;
  logic                   w_wr_cnt;
  logic                   w_wr_cmp;
  logic                   w_wr_presc;
  logic                   w_sr_clr;
  logic                   w_clr;
  logic [31:0]            w_be_mask;
  logic [31:0]            w_cnt_ext;
  logic [31:0]            w_cmp_ext;
  logic [31:0]            w_presc_ext;
  logic [31:0]            w_cnt_merge;
  logic [31:0]            w_cmp_merge;
  logic [31:0]            w_presc_merge;
  logic                   w_tick;
  logic                   w_hit;
  logic [31:0]            w_rd_data;

  logic                   w_en_nxt;
  logic                   w_ie_nxt;
  logic                   w_oneshot_nxt;
  logic                   w_match_nxt;
  logic [CNT_WIDTH-1:0]   w_cnt_nxt;
  logic [CNT_WIDTH-1:0]   w_cmp_nxt;
  logic [PRESC_WIDTH-1:0] w_presc_nxt;
  logic [PRESC_WIDTH-1:0] w_psc_nxt;

  // Every request is accepted in the cycle it is presented.
  assign gnt    = req;
  assign rvalid = r_rvalid;
  assign rdata  = r_rdata;
  assign err    = r_err;
  assign irq    = r_irq;

  assign w_idx    = addr[4:2];
  assign w_mapped = (w_idx <= RegPresc);
  assign w_wr     = req & we;

  // All CR/SR control bits live in byte 0, so be[0] gates those registers entirely.
  assign w_wr_cr    = w_wr & (w_idx == RegCr) & be[0];
  assign w_sr_clr   = w_wr & (w_idx == RegSr) & be[0] & wdata[0];
  assign w_wr_cnt   = w_wr & (w_idx == RegCnt);
  assign w_wr_cmp   = w_wr & (w_idx == RegCmp);
  assign w_wr_presc = w_wr & (w_idx == RegPresc);
  assign w_clr      = w_wr_cr & wdata[3];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_be_mask[8*i +: 8] = {8{be[i]}};
    end
  end

  always_comb begin
    w_cnt_ext                     = '0;
    w_cmp_ext                     = '0;
    w_presc_ext                   = '0;
    w_cnt_ext[CNT_WIDTH-1:0]      = r_cnt;
    w_cmp_ext[CNT_WIDTH-1:0]      = r_cmp;
    w_presc_ext[PRESC_WIDTH-1:0]  = r_presc;
  end

  assign w_cnt_merge   = (w_cnt_ext & ~w_be_mask) | (wdata & w_be_mask);
  assign w_cmp_merge   = (w_cmp_ext & ~w_be_mask) | (wdata & w_be_mask);
  assign w_presc_merge = (w_presc_ext & ~w_be_mask) | (wdata & w_be_mask);

  assign w_tick = r_en & (r_psc == r_presc);
  assign w_hit  = w_tick & (r_cnt == r_cmp);

  always_comb begin
    w_psc_nxt = r_psc;
    if (w_clr) begin
      w_psc_nxt = '0;
    end else if (r_en) begin
      w_psc_nxt = w_tick ? '0 : r_psc + PRESC_WIDTH'(1);
    end
  end

  // Priority for CNT: CLR, then software write, then the tick update.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_clr) begin
      w_cnt_nxt = '0;
    end else if (w_wr_cnt) begin
      w_cnt_nxt = w_cnt_merge[CNT_WIDTH-1:0];
    end else if (w_tick) begin
      w_cnt_nxt = w_hit ? '0 : r_cnt + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    w_en_nxt      = r_en;
    w_ie_nxt      = r_ie;
    w_oneshot_nxt = r_oneshot;
    if (w_wr_cr) begin
      w_en_nxt      = wdata[0];
      w_ie_nxt      = wdata[1];
      w_oneshot_nxt = wdata[2];
    end else if (w_hit && r_oneshot) begin
      w_en_nxt = 1'b0;
    end
  end

  // A hardware match in the same cycle as a W1C keeps the flag set.
  always_comb begin
    w_match_nxt = r_match;
    if (w_hit) begin
      w_match_nxt = 1'b1;
    end else if (w_sr_clr) begin
      w_match_nxt = 1'b0;
    end
  end

  assign w_cmp_nxt   = w_wr_cmp ? w_cmp_merge[CNT_WIDTH-1:0] : r_cmp;
  assign w_presc_nxt = w_wr_presc ? w_presc_merge[PRESC_WIDTH-1:0] : r_presc;

  always_comb begin
    w_rd_data = '0;
    case (w_idx)
      RegCr:    w_rd_data = {29'd0, r_oneshot, r_ie, r_en};
      RegSr:    w_rd_data = {31'd0, r_match};
      RegCnt:   w_rd_data = w_cnt_ext;
      RegCmp:   w_rd_data = w_cmp_ext;
      RegPresc: w_rd_data = w_presc_ext;
      default:  w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en      <= 1'b0;
      r_ie      <= 1'b0;
      r_oneshot <= 1'b0;
      r_match   <= 1'b0;
      r_cnt     <= '0;
      r_cmp     <= '0;
      r_presc   <= '0;
      r_psc     <= '0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_en      <= w_en_nxt;
      r_ie      <= w_ie_nxt;
      r_oneshot <= w_oneshot_nxt;
      r_match   <= w_match_nxt;
      r_cnt     <= w_cnt_nxt;
      r_cmp     <= w_cmp_nxt;
      r_presc   <= w_presc_nxt;
      r_psc     <= w_psc_nxt;
      r_rvalid  <= req;
      r_rdata   <= (req && !we) ? w_rd_data : 32'd0;
      r_err     <= req & ~w_mapped;
      r_irq     <= r_match & r_ie;
    end
  end

endmodule

// File: doc/soc_timer_irq_unit.md
Name: soc_timer_irq_unit

Overview:
Memory-mapped compare timer that feeds the core's fast-interrupt line irq_fast_i[1].
Slave on the core data bus (req/gnt/rvalid protocol), selected by the peripherals decoder.
Provides a prescaled up-counter, a compare register, a match flag and a level interrupt.

Parameters:
CNT_WIDTH, 32, counter/compare width (1..32); register reads are zero-extended to 32 bits.
PRESC_WIDTH, 16, prescaler width (1..32).

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req  in  1  bus request, already address-decoded for this block
we  in  1  1 = write, 0 = read
be  in  4  byte enables for writes
addr  in  5  byte offset; addr[4:2] selects the register, addr[1:0] is ignored
wdata  in  32  write data
gnt  out  1  grant
rvalid  out  1  response valid
rdata  out  32  read data
err  out  1  error response, qualified by rvalid
irq  out  1  level interrupt to the core

Behaviour:
- Register map (word offsets):
  - 0x00 CR: bit0 EN, bit1 IE, bit2 ONESHOT, bit3 CLR (write-only, self-clearing, reads 0).
  - 0x04 SR: bit0 MATCH, write-1-to-clear.
  - 0x08 CNT: read/write.
  - 0x0C CMP: read/write.
  - 0x10 PRESC: read/write.
  - Offsets 0x14-0x1C are unmapped.
- Reset values: gnt=0, rvalid=0, rdata=0, err=0, irq=0; all registers 0; prescaler counter 0.
- Handshake:
  - gnt = req, combinational; each request is accepted in the cycle it is asserted.
  - rvalid pulses exactly 1 cycle after acceptance, for reads and writes alike.
  - rdata and err are registered and valid only with rvalid. rdata=0 for writes.
  - Back-to-back requests on consecutive cycles are supported.
- Unmapped offset: err=1 with rvalid, rdata=0, no state change.
- Writes:
  - Honour be per byte.
  - Bits beyond CNT_WIDTH/PRESC_WIDTH are dropped; undefined CR/SR bits are ignored.
- Prescaler:
  - While EN=1, psc increments every cycle.
  - When psc==PRESC, a tick occurs that cycle and psc returns to 0. PRESC=0 gives a tick every cycle.
  - While EN=0, psc holds.
- Tick handling:
  - If CNT==CMP: CNT<=0, MATCH<=1, and EN<=0 if ONESHOT=1.
  - Otherwise CNT<=CNT+1, wrapping at 2^CNT_WIDTH without setting MATCH.
- irq: registered; irq <= MATCH & IE, so it follows a MATCH/IE change with 1 cycle latency.
- Precedence (same cycle):
  - Software write to CNT beats tick update.
  - CLR=1 sets CNT<=0 and psc<=0, beats tick and CNT write.
  - Hardware MATCH set beats SR W1C clear.
  - A CR write with EN=0 beats ONESHOT auto-clear (same result).
  - Write to CMP takes effect for compares from the next cycle.
- Reads return the register value before any same-cycle update.
- Reset asserted mid-transaction: the pending rvalid is dropped (0 next cycle) and all state returns to reset values.

Test Plan:
1. Reset, then read 0x00..0x10 -> each gives gnt same cycle, rvalid next cycle, rdata=0, err=0; irq=0.
2. PRESC=3, CMP=2, CR=0x3 -> CNT increments every 4 cycles. 12 cycles after enable, MATCH=1, CNT=0. irq=1 one cycle later, stays high until SR written 0x1, then drops 1 cycle after.
3. ONESHOT: PRESC=0, CMP=5, CR=0x7 -> match after 6 ticks; CR reads 0x6 and CNT stays 0 afterwards.
4. Write CNT=0xFFFF_FFFF with CMP=0x10, PRESC=0, EN=1 -> next tick CNT=0 with MATCH=0 (wrap); MATCH sets 17 ticks later.
5. Collisions:
   - SR W1C in the same cycle as a match -> MATCH remains 1.
   - CNT write of 0x40 coinciding with a tick -> CNT reads 0x40.
   - CLR with a CNT write -> CNT=0.
6. Read 0x18 -> rvalid with err=1, rdata=0.
   Back-to-back: write CMP with be=4'b0010 and wdata=0xAABBCCDD -> CMP=0x0000CC00; the next-cycle read returns it.
   Assert rst on the rvalid-pending cycle -> rvalid=0 next cycle.
